cache_controller: RTL and testbench

- Direct-mapped, write-back, write-allocate cache controller that sits directly upstream of main_memory.
- Serves 32-bit word requests from the CPU side.
- Stores 4 lines of 128 bits on-chip (tag, valid, dirty and data arrays).
- On misses, sequences block write-backs and refills over main_memory's read/write-select, 10-bit byte-address, 128-bit data interface.
- Models memory access time with a fixed-cycle wait counter.

---
 rtl/cache_controller.sv | 175 +++++++++++++++++
 tb/tb_cache_controller.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// Direct-mapped, write-back, write-allocate cache in front of a block-wide main memory.
// Misses write back a dirty victim, then refill the line, each phase held for MEM_LATENCY cycles.
module cache_controller #(
  parameter int unsigned NUM_LINES   = 4,
  parameter int unsigned BLOCK_BITS  = 128,
  parameter int unsigned MEM_LATENCY = 4
) (
  input  logic                  in_clk,
  input  logic                  in_rst,
  input  logic                  in_req,
  input  logic                  in_we,
  input  logic [9:0]            in_addr,
  input  logic [31:0]           in_write_data,
  output logic [31:0]           out_read_data,
  output logic                  out_done,
  output logic                  out_hit,
  output logic                  out_busy,
  output logic                  out_mem_row,
  output logic [9:0]            out_mem_addr,
  output logic [BLOCK_BITS-1:0] out_mem_write_data,
  input  logic [BLOCK_BITS-1:0] in_mem_read_data
);
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned OFF_W  = $clog2(BLOCK_BITS / 8);
  localparam int unsigned WORD_W = OFF_W - 2;
  localparam int unsigned IDX_W  = $clog2(NUM_LINES);
  localparam int unsigned TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int unsigned CNT_W  = $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, COMPARE, WRITE_BACK, ALLOCATE} state_t;

  state_t                state, state_next;
  logic [TAG_W-1:0]      req_tag;
  logic [IDX_W-1:0]      req_idx;
  logic [WORD_W-1:0]     req_word;
  logic                  req_we;
  logic [31:0]           req_wdata;
  logic                  first_miss;
  logic [CNT_W-1:0]      cnt;
  logic [NUM_LINES-1:0]  valid, dirty;
  logic [TAG_W-1:0]      tag_mem  [NUM_LINES];
  logic [BLOCK_BITS-1:0] data_mem [NUM_LINES];

  logic                  hit_c;
  logic [31:0]           hit_word_c;
  logic                  done_n, hit_n, busy_n, row_n;
  logic [31:0]           rdata_n;
  logic [9:0]            maddr_n;
  logic [BLOCK_BITS-1:0] mwdata_n;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^in_addr[1:0];
  assign hit_c      = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign hit_word_c = data_mem[req_idx][{req_word, 5'd0} +: 32];

  // State register
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (in_req) state_next = COMPARE;
      COMPARE: begin
        if (hit_c)                                  state_next = IDLE;
        else if (valid[req_idx] && dirty[req_idx])  state_next = WRITE_BACK;
        else                                        state_next = ALLOCATE;
      end
      WRITE_BACK: if (cnt == '0) state_next = ALLOCATE;
      ALLOCATE:   if (cnt == '0) state_next = COMPARE;
      default:    state_next = IDLE;
    endcase
  end

  // Output values for the coming cycle, keyed on the next state so memory controls align with it
  always_comb begin
    done_n   = (state == COMPARE) && hit_c;
    hit_n    = done_n && !first_miss;
    rdata_n  = (done_n && !req_we) ? hit_word_c : out_read_data;
    busy_n   = (state_next != IDLE);
    row_n    = (state_next == WRITE_BACK);
    maddr_n  = out_mem_addr;
    mwdata_n = out_mem_write_data;
    if (state_next == WRITE_BACK) begin
      maddr_n  = {tag_mem[req_idx], req_idx, OFF_W'(0)};
      mwdata_n = data_mem[req_idx];
    end else if (state_next == ALLOCATE) begin
      maddr_n  = {req_tag, req_idx, OFF_W'(0)};
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      out_done           <= 1'b0;
      out_hit            <= 1'b0;
      out_busy           <= 1'b0;
      out_mem_row        <= 1'b0;
      out_read_data      <= '0;
      out_mem_addr       <= '0;
      out_mem_write_data <= '0;
    end else begin
      out_done           <= done_n;
      out_hit            <= hit_n;
      out_busy           <= busy_n;
      out_mem_row        <= row_n;
      out_read_data      <= rdata_n;
      out_mem_addr       <= maddr_n;
      out_mem_write_data <= mwdata_n;
    end
  end

  // Request latch, line status bits and memory-phase counter
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      valid      <= '0;
      dirty      <= '0;
      cnt        <= '0;
      first_miss <= 1'b0;
      req_we     <= 1'b0;
      req_tag    <= '0;
      req_idx    <= '0;
      req_word   <= '0;
      req_wdata  <= '0;
    end else begin
      case (state)
        IDLE: if (in_req) begin
          req_we     <= in_we;
          req_tag    <= in_addr[ADDR_W-1:OFF_W+IDX_W];
          req_idx    <= in_addr[OFF_W+IDX_W-1:OFF_W];
          req_word   <= in_addr[OFF_W-1:2];
          req_wdata  <= in_write_data;
          first_miss <= 1'b0;
        end
        COMPARE: begin
          if (hit_c) begin
            if (req_we) dirty[req_idx] <= 1'b1;
          end else begin
            first_miss <= 1'b1;
            cnt        <= CNT_W'(MEM_LATENCY - 1);
          end
        end
        WRITE_BACK: begin
          if (cnt == '0) begin
            dirty[req_idx] <= 1'b0;
            cnt            <= CNT_W'(MEM_LATENCY - 1);
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ALLOCATE: begin
          if (cnt == '0) begin
            valid[req_idx] <= 1'b1;
            dirty[req_idx] <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and data arrays carry no reset; valid bits gate their use
  always_ff @(posedge in_clk) begin
    if (state == COMPARE && hit_c && req_we)
      data_mem[req_idx][{req_word, 5'd0} +: 32] <= req_wdata;
    if (state == ALLOCATE && cnt == '0) begin
      data_mem[req_idx] <= in_mem_read_data;
      tag_mem[req_idx]  <= req_tag;
    end
  end
endmodule

// File: tb/tb_cache_controller.sv
// Randomized scoreboard bench for cache_controller against an abstract cache + memory model.
// Block n of the memory model starts with value n in word 0 and zeros elsewhere.
module tb_cache_controller;
  localparam int unsigned L = 4;

  logic         clk = 1'b0, rst = 1'b1, req = 1'b0, we = 1'b0;
  logic [9:0]   addr = '0;
  logic [31:0]  wdata = '0;
  logic [31:0]  read_data;
  logic         done, hit, busy, mem_row;
  logic [9:0]   mem_addr;
  logic [127:0] mem_wdata, mem_rdata;

  cache_controller #(.NUM_LINES(4), .BLOCK_BITS(128), .MEM_LATENCY(L)) dut (
    .in_clk(clk), .in_rst(rst), .in_req(req), .in_we(we), .in_addr(addr),
    .in_write_data(wdata), .out_read_data(read_data), .out_done(done), .out_hit(hit),
    .out_busy(busy), .out_mem_row(mem_row), .out_mem_addr(mem_addr),
    .out_mem_write_data(mem_wdata), .in_mem_read_data(mem_rdata)
  );

  always #5 clk = ~clk;

  // main_memory stand-in
  logic [127:0] mem [64];
  assign mem_rdata = mem[mem_addr[9:4]];
  always @(posedge clk) if (mem_row) mem[mem_addr[9:4]] <= mem_wdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;

  typedef struct {
    logic [31:0] data;
    logic        hit;
    logic        rd;
    int          issue;
    int          lat;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  // Reference model: the cache as the spec describes it, plus what memory should hold
  logic         mvalid [4];
  logic         mdirty [4];
  logic [3:0]   mtag   [4];
  logic [127:0] mdata  [4];
  logic [127:0] ref_mem [64];

  int           row_cnt = 0;
  logic [9:0]   wb_addr = '0;
  logic [127:0] wb_data = '0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // Monitor: pops the scoreboard on each completion, watches memory write exposure
  always @(negedge clk) begin
    if (mem_row) begin
      row_cnt++;
      wb_addr = mem_addr;
      wb_data = mem_wdata;
      chk("row_only_when_busy", 128'(busy), 128'(1));
    end
    if (done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 128'(done), 128'(0));
      end else begin
        mon_e = sb.pop_front();
        chk("hit_flag", 128'(hit), 128'(mon_e.hit));
        chk("latency", 128'(cyc - mon_e.issue), 128'(mon_e.lat));
        if (mon_e.rd) chk("read_data", 128'(read_data), 128'(mon_e.data));
      end
    end else if (hit) begin
      chk("hit_without_done", 128'(hit), 128'(0));
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mvalid[i] = 1'b0;
      mdirty[i] = 1'b0;
    end
  endtask

  task automatic do_req(input logic w, input logic [9:0] a, input logic [31:0] d);
    int           idx = int'(a[5:4]);
    int           wd  = int'(a[3:2]);
    logic [3:0]   tg  = a[9:6];
    logic         mh, md;
    int           exp_rows;
    logic [9:0]   exp_wa = '0;
    logic [127:0] exp_wd = '0;
    exp_t         e;
    bit           finished = 1'b0;
    mh = mvalid[idx] && (mtag[idx] == tg);
    md = !mh && mvalid[idx] && mdirty[idx];
    exp_rows = md ? int'(L) : 0;
    if (md) begin
      exp_wa = {mtag[idx], 2'(idx), 4'b0};
      exp_wd = mdata[idx];
      ref_mem[{mtag[idx], 2'(idx)}] = mdata[idx];
    end
    if (!mh) begin
      mdata[idx]  = ref_mem[a[9:4]];
      mtag[idx]   = tg;
      mvalid[idx] = 1'b1;
      mdirty[idx] = 1'b0;
    end
    e.hit  = mh;
    e.rd   = !w;
    e.lat  = mh ? 2 : (md ? int'(2 * L + 3) : int'(L + 3));
    e.data = mdata[idx][wd*32 +: 32];
    if (w) begin
      mdata[idx][wd*32 +: 32] = d;
      mdirty[idx] = 1'b1;
    end
    req = 1'b1; we = w; addr = a; wdata = d;
    e.issue = cyc;
    row_cnt = 0;
    sb.push_back(e);
    @(posedge clk); #1;
    req = 1'b0;
    for (int k = 0; k < 60; k++) begin
      req = 1'b0;
      if (sb.size() == 0 && !busy) begin
        finished = 1'b1;
        break;
      end
      if (sb.size() != 0 && !done) chk("busy_during_op", 128'(busy), 128'(1));
      // Requests while busy must be dropped, not queued
      if (busy) req = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    req = 1'b0;
    if (!finished) begin
      chk("completion_timeout", 128'(sb.size()), 128'(0));
      sb.delete();
    end
    chk("writeback_cycles", 128'(row_cnt), 128'(exp_rows));
    if (md) begin
      chk("writeback_addr", 128'(wb_addr), 128'(exp_wa));
      chk("writeback_data", wb_data, exp_wd);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_row", 128'(mem_row), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    sb.delete();
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 128'(i);
      ref_mem[i] = 128'(i);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_done", 128'(done), 128'(0));
    chk("reset_hit", 128'(hit), 128'(0));
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_row", 128'(mem_row), 128'(0));
    chk("reset_read_data", 128'(read_data), 128'(0));
    chk("reset_mem_addr", 128'(mem_addr), 128'(0));
    chk("reset_mem_wdata", mem_wdata, 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed sequence from the test plan
    do_req(1'b0, 10'h010, 32'h0);
    chk("tp_first_read", 128'(read_data), 128'h1);
    do_req(1'b0, 10'h010, 32'h0);
    do_req(1'b1, 10'h014, 32'hDEADBEEF);
    do_req(1'b0, 10'h054, 32'h0);
    chk("tp_wb_addr", 128'(wb_addr), 128'h010);
    chk("tp_wb_data", wb_data, 128'hDEADBEEF_00000001);
    chk("tp_evict_read", 128'(read_data), 128'h0);
    do_req(1'b0, 10'h014, 32'h0);
    chk("tp_reload_read", 128'(read_data), 128'hDEADBEEF);
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < 4; s++) do_req(1'b0, 10'(s * 16), 32'h0);

    // Reset in the middle of a refill
    do_reset();
    req = 1'b1; we = 1'b0; addr = 10'h020;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_alloc_busy", 128'(busy), 128'(1));
    do_reset();
    do_req(1'b0, 10'h020, 32'h0);

    // Random traffic; half the time confined to two tags so hits and dirty evictions are common
    for (int n = 0; n < 300; n++) begin
      logic [9:0] a;
      a = 10'($urandom);
      if ($urandom_range(0, 1) == 1) a = a & 10'h07F;
      do_req(1'($urandom_range(0, 1)), a, $urandom);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 128'(sb.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
